ram_rr_bridge: RTL and testbench
================================

# ram_rr_bridge

Parametrised RAM access bridge between `NCH` independent requester channels (e.g. instruction fetch, load/store) and one single-port `RAMHelper`-style simulation memory in the difftest top. Requests are granted round-robin, one per cycle, and translated to word indices relative to the program start address. Byte masks are expanded to bit masks. Each response returns after a configurable `LAT` cycles, with out-of-range detection. The bridge replaces the fixed single-channel, one-cycle-ready glue in the simulation top.

## Interface
- `NCH`, 2, number of requester channels (1..8)
- `DW`, 64, data width; `DW/8` byte lanes
- `AW`, 64, request address width
- `IDX_W`, 16, RAM word-index width
- `LAT`, 1, response latency in cycles after grant (1..4)
- `BASE`, `` `PC_START ``, byte address of RAM word 0
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `req_cen_i`  in  NCH  per-channel request; level, held until `rsp_ready_o`
- `req_wen_i`  in  NCH  1 = write
- `req_addr_i`  in  NCH*AW  byte address, channel c at `[c*AW +: AW]`
- `req_wdata_i`  in  NCH*DW  write data
- `req_wmask_i`  in  NCH*DW/8  byte write enables
- `req_gnt_o`  out  NCH  one-hot grant, combinational, this cycle
- `rsp_ready_o`  out  NCH  one-cycle response pulse
- `rsp_data_o`  out  NCH*DW  read data, registered, held between reads
- `rsp_err_o`  out  NCH  out-of-range flag, valid with `rsp_ready_o`
- `ram_en_o`  out  1  RAM enable
- `ram_wen_o`  out  1  RAM write enable
- `ram_idx_o`  out  IDX_W  RAM read/write index
- `ram_wdata_o`  out  DW  RAM write data
- `ram_wmask_o`  out  DW  bit mask; each byte bit replicated ×8
- `ram_rdata_i`  in  DW  RAM read data, combinational from `ram_idx_o`

## Operation
- **Eligibility.** Channel c is eligible when `req_cen_i[c]` is high, `busy[c]` is low, and `rsp_ready_o[c]` is low this cycle.
- **Arbitration.** Round-robin pointer `last`. Search starts at `(last+1) mod NCH`, and the first eligible channel is granted. On a grant, `last` takes the granted channel and `busy[c]` is set.
- **Index arithmetic.**
  - `off = addr - BASE` (AW-bit unsigned).
  - `ram_idx_o = off[IDX_W+2:3]`.
  - Out of range when `addr < BASE` or `off[AW-1:IDX_W+3] != 0`.
- **Granted, in range.**
  - `ram_en_o = 1`.
  - `ram_wen_o` = channel wen.
  - `ram_wdata_o` and expanded `ram_wmask_o` are driven from the granted channel.
- **Granted, out of range.** `ram_en_o = 0`; no memory access occurs.
- **No grant.** All `ram_*` outputs are 0.
- **Response pipeline.** `LAT` stages, each holding {valid, ch, wen, err, data}. Stage 0 captures `ram_rdata_i` at the grant edge; stages then shift.
- **At the last stage (valid):**
  - `rsp_ready_o[ch]` pulses for one cycle.
  - `rsp_err_o[ch]` = err.
  - `busy[ch]` is cleared.
  - If it is a read without error, `rsp_data_o[ch]` is updated with the captured data.
  - If it is a read with error, `rsp_data_o[ch]` is updated with 0.
  - Writes leave `rsp_data_o[ch]` unchanged.
- **Requester protocol.** The requester must deassert `req_cen_i`, or present a new request, in the cycle after `rsp_ready_o`. A still-high `cen` is treated as a new request.

## Timing
- Grant in cycle T → `rsp_ready_o` in cycle T+LAT. With LAT=1 this is one cycle, matching the legacy glue.
- **Throughput.** One grant per cycle across channels. At most one outstanding request per channel.
- **Same-channel back-to-back.** A channel cannot be re-granted in its `rsp_ready` cycle, so its minimum spacing is LAT+1 cycles.
- **Simultaneous events.** A response to channel a and a grant to channel b≠a may occur in the same cycle.
- **Reset values (asserted asynchronously).**
  - `last = NCH-1`, so channel 0 wins first.
  - `busy = 0`; all pipeline valids = 0.
  - `rsp_ready_o = 0`, `rsp_err_o = 0`, `rsp_data_o = 0`.
- **Reset mid-operation.** In-flight accesses are dropped and no response is emitted. Writes already issued to the RAM are not undone.

## Structure
- `BASE` default is taken from `` `PC_START `` in `defines.v`.
- Add `` `RAM_IDX_W `` and `` `RAM_LAT `` to `defines.v` so the top and the bridge agree.
- One sub-module, `rr_arbiter`:
  - Parameter `NCH`.
  - Inputs: eligible vector, `last`.
  - Outputs: one-hot grant, granted index.
  - Purely combinational; `last` register lives in the bridge.

## Test plan
- **Single read.** NCH=2, LAT=1, `BASE=0x80000000`. Ch0 reads `0x80000010` → `ram_idx_o=2`, `gnt[0]` in T, `rsp_ready_o[0]` in T+1, `rsp_data_o[0]` = RAM word 2.
- **Contention.** Ch0 and ch1 both request from reset → grants ch0 (T), ch1 (T+1). Ch0 re-requests after its response → grant order alternates 0,1,0,1 with no starvation.
- **Masked write.** Ch1 writes `0x80000008`, wmask `0x0F`, data `0x1122334455667788` → `ram_wmask_o=0x00000000FFFFFFFF`, `ram_wen_o=1`. A following read returns the low 4 bytes updated.
- **Out of range.**
  - Ch0 reads `0x7FFFFFF8` → `ram_en_o=0`, `rsp_err_o[0]=1`, `rsp_data_o[0]=0`.
  - Ch0 reads `BASE + 2^(IDX_W+3)` → same response.
- **Latency.** LAT=3, ch0 read in T, ch1 read in T+1 → `rsp_ready_o[0]` at T+3, `rsp_ready_o[1]` at T+4. Ch0 is not re-granted before T+4.
- **Reset mid-flight.** With LAT=3, assert `reset` at T+1 after a grant at T → no `rsp_ready_o` pulse afterwards. After release, ch0 is granted first.

Source files
------------

// File: rtl/ram_rr_bridge_pkg.sv
// ram_rr_bridge_pkg: shared constants for the RAM bridge and the simulation top.
//   PC_START   - byte address of RAM word 0 (program start)
//   RAM_IDX_W  - RAM word-index width shared by the top and the bridge
//   RAM_LAT    - default response latency in cycles after grant
//   ch_width() - index width for a channel count (at least 1 bit)
package ram_rr_bridge_pkg;

    localparam logic [63:0] PC_START  = 64'h0000_0000_8000_0000;
    localparam int unsigned RAM_IDX_W = 16;
    localparam int unsigned RAM_LAT   = 1;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_rr_bridge_arb.sv
// rr_arbiter: combinational round-robin arbiter.
//   elig_i  - per-channel eligible vector
//   last_i  - channel granted most recently (search starts after it)
//   gnt_o   - one-hot grant
//   idx_o   - index of the granted channel
//   valid_o - a channel was granted
module rr_arbiter
    import ram_rr_bridge_pkg::*;
#(
    parameter int unsigned NCH = 2,
    localparam int unsigned CW = ch_width(NCH)
) (
    input  logic [NCH-1:0] elig_i,
    input  logic [CW-1:0]  last_i,
    output logic [NCH-1:0] gnt_o,
    output logic [CW-1:0]  idx_o,
    output logic           valid_o
);

    int unsigned c;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        // Walk last+1 .. last+NCH (mod NCH); the first eligible channel wins.
        for (int unsigned k = 1; k <= NCH; k++) begin
            c = (32'(last_i) + k) % NCH;
            if (!valid_o && elig_i[c]) begin
                gnt_o[c] = 1'b1;
                idx_o    = CW'(c);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_rr_bridge.sv
// ram_rr_bridge: round-robin bridge from NCH requester channels to one single-port RAM.
//   clock, reset        - sole clock, asynchronous active-high reset
//   req_*_i             - per-channel request (level, held until rsp_ready_o)
//   req_gnt_o           - one-hot grant this cycle (combinational)
//   rsp_ready_o/err_o   - one-cycle response pulse and out-of-range flag
//   rsp_data_o          - per-channel read data, held between reads
//   ram_*_o, ram_rdata_i - RAM port; read data is combinational from ram_idx_o
module ram_rr_bridge
    import ram_rr_bridge_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DW    = 64,
    parameter int unsigned AW    = 64,
    parameter int unsigned IDX_W = RAM_IDX_W,
    parameter int unsigned LAT   = RAM_LAT,
    parameter logic [AW-1:0] BASE = AW'(PC_START)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NCH-1:0]      req_cen_i,
    input  logic [NCH-1:0]      req_wen_i,
    input  logic [NCH*AW-1:0]   req_addr_i,
    input  logic [NCH*DW-1:0]   req_wdata_i,
    input  logic [NCH*DW/8-1:0] req_wmask_i,
    output logic [NCH-1:0]      req_gnt_o,
    output logic [NCH-1:0]      rsp_ready_o,
    output logic [NCH*DW-1:0]   rsp_data_o,
    output logic [NCH-1:0]      rsp_err_o,
    output logic                ram_en_o,
    output logic                ram_wen_o,
    output logic [IDX_W-1:0]    ram_idx_o,
    output logic [DW-1:0]       ram_wdata_o,
    output logic [DW-1:0]       ram_wmask_o,
    input  logic [DW-1:0]       ram_rdata_i
);

    localparam int unsigned CW = ch_width(NCH);
    localparam int unsigned MW = DW / 8;

    logic [CW-1:0]     last_q;
    logic [NCH-1:0]    busy_q, busy_d;
    logic [NCH*DW-1:0] data_q;

    // Response pipeline; stage LAT-1 is the one that responds.
    logic          pipe_valid_q [LAT];
    logic [CW-1:0] pipe_ch_q    [LAT];
    logic          pipe_wen_q   [LAT];
    logic          pipe_err_q   [LAT];
    logic [DW-1:0] pipe_data_q  [LAT];

    logic [NCH-1:0] elig;
    logic [CW-1:0]  gnt_idx;
    logic           gnt_valid;
    logic [AW-1:0]  sel_addr, off;
    logic           sel_wen, in_range;
    logic [DW-1:0]  sel_wdata;
    logic [MW-1:0]  sel_wmask;
    logic           unused_off;

    // Entry about to move into the last stage; rsp_data_o is loaded from it so the
    // new data is visible in the same cycle as rsp_ready_o.
    logic          pre_valid, pre_wen, pre_err;
    logic [CW-1:0] pre_ch;
    logic [DW-1:0] pre_data;

    assign elig = req_cen_i & ~busy_q & ~rsp_ready_o;

    rr_arbiter #(
        .NCH(NCH)
    ) u_arb (
        .elig_i (elig),
        .last_i (last_q),
        .gnt_o  (req_gnt_o),
        .idx_o  (gnt_idx),
        .valid_o(gnt_valid)
    );

    always_comb begin
        sel_addr  = req_addr_i[gnt_idx*AW +: AW];
        sel_wen   = req_wen_i[gnt_idx];
        sel_wdata = req_wdata_i[gnt_idx*DW +: DW];
        sel_wmask = req_wmask_i[gnt_idx*MW +: MW];
        off       = sel_addr - BASE;
        in_range  = (sel_addr >= BASE) && (off[AW-1:IDX_W+3] == '0);

        ram_en_o    = 1'b0;
        ram_wen_o   = 1'b0;
        ram_idx_o   = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        if (gnt_valid && in_range) begin
            ram_en_o    = 1'b1;
            ram_wen_o   = sel_wen;
            ram_idx_o   = off[IDX_W+2:3];
            ram_wdata_o = sel_wdata;
            for (int unsigned b = 0; b < MW; b++) begin
                ram_wmask_o[b*8 +: 8] = {8{sel_wmask[b]}};
            end
        end
    end

    // Byte offset within the word is ignored; accesses are word-aligned.
    assign unused_off = ^off[2:0];

    always_comb begin
        rsp_ready_o = '0;
        rsp_err_o   = '0;
        if (pipe_valid_q[LAT-1]) begin
            rsp_ready_o[pipe_ch_q[LAT-1]] = 1'b1;
            rsp_err_o[pipe_ch_q[LAT-1]]   = pipe_err_q[LAT-1];
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (pipe_valid_q[LAT-1]) begin
            busy_d[pipe_ch_q[LAT-1]] = 1'b0;
        end
        if (gnt_valid) begin
            busy_d = busy_d | req_gnt_o;
        end
    end

    if (LAT == 1) begin : g_pre_direct
        assign pre_valid = gnt_valid;
        assign pre_ch    = gnt_idx;
        assign pre_wen   = sel_wen;
        assign pre_err   = !in_range;
        assign pre_data  = ram_rdata_i;
    end else begin : g_pre_pipe
        assign pre_valid = pipe_valid_q[LAT-2];
        assign pre_ch    = pipe_ch_q[LAT-2];
        assign pre_wen   = pipe_wen_q[LAT-2];
        assign pre_err   = pipe_err_q[LAT-2];
        assign pre_data  = pipe_data_q[LAT-2];
    end

    assign rsp_data_o = data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= CW'(NCH - 1);
            busy_q <= '0;
            data_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_ch_q[i]    <= '0;
                pipe_wen_q[i]   <= 1'b0;
                pipe_err_q[i]   <= 1'b0;
                pipe_data_q[i]  <= '0;
            end
        end else begin
            if (gnt_valid) begin
                last_q <= gnt_idx;
            end
            busy_q <= busy_d;

            pipe_valid_q[0] <= gnt_valid;
            pipe_ch_q[0]    <= gnt_idx;
            pipe_wen_q[0]   <= sel_wen;
            pipe_err_q[0]   <= !in_range;
            pipe_data_q[0]  <= ram_rdata_i;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_ch_q[i]    <= pipe_ch_q[i-1];
                pipe_wen_q[i]   <= pipe_wen_q[i-1];
                pipe_err_q[i]   <= pipe_err_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
            end

            // Writes leave the channel's read data untouched.
            if (pre_valid && !pre_wen) begin
                data_q[pre_ch*DW +: DW] <= pre_err ? '0 : pre_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_rr_bridge.sv
// tb_ram_rr_bridge: directed bench for ram_rr_bridge with two instances,
// one at LAT=1 (u_dut1) and one at LAT=3 (u_dut3), each with its own RAM model.
module tb_ram_rr_bridge;

    logic clk;
    logic rst1, rst3;

    logic [1:0]   cen1, wen1, gnt1, rdy1, err1;
    logic [127:0] addr1, wdata1, rdata_o1;
    logic [15:0]  wmask1;
    logic         ram_en1, ram_wen1;
    logic [15:0]  idx1;
    logic [63:0]  ram_wdata1, ram_wmask1, ram_rdata1;

    logic [1:0]   cen3, wen3, gnt3, rdy3, err3;
    logic [127:0] addr3, wdata3, rdata_o3;
    logic [15:0]  wmask3;
    logic         ram_en3, ram_wen3;
    logic [15:0]  idx3;
    logic [63:0]  ram_wdata3, ram_wmask3, ram_rdata3;

    logic [63:0] mem1 [0:65535];
    logic [63:0] mem3 [0:65535];

    int n_pass;
    int n_total;

    ram_rr_bridge #(
        .NCH(2), .DW(64), .AW(64), .IDX_W(16), .LAT(1), .BASE(64'h8000_0000)
    ) u_dut1 (
        .clock      (clk),
        .reset      (rst1),
        .req_cen_i  (cen1),
        .req_wen_i  (wen1),
        .req_addr_i (addr1),
        .req_wdata_i(wdata1),
        .req_wmask_i(wmask1),
        .req_gnt_o  (gnt1),
        .rsp_ready_o(rdy1),
        .rsp_data_o (rdata_o1),
        .rsp_err_o  (err1),
        .ram_en_o   (ram_en1),
        .ram_wen_o  (ram_wen1),
        .ram_idx_o  (idx1),
        .ram_wdata_o(ram_wdata1),
        .ram_wmask_o(ram_wmask1),
        .ram_rdata_i(ram_rdata1)
    );

    ram_rr_bridge #(
        .NCH(2), .DW(64), .AW(64), .IDX_W(16), .LAT(3), .BASE(64'h8000_0000)
    ) u_dut3 (
        .clock      (clk),
        .reset      (rst3),
        .req_cen_i  (cen3),
        .req_wen_i  (wen3),
        .req_addr_i (addr3),
        .req_wdata_i(wdata3),
        .req_wmask_i(wmask3),
        .req_gnt_o  (gnt3),
        .rsp_ready_o(rdy3),
        .rsp_data_o (rdata_o3),
        .rsp_err_o  (err3),
        .ram_en_o   (ram_en3),
        .ram_wen_o  (ram_wen3),
        .ram_idx_o  (idx3),
        .ram_wdata_o(ram_wdata3),
        .ram_wmask_o(ram_wmask3),
        .ram_rdata_i(ram_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata1 = mem1[idx1];
    assign ram_rdata3 = mem3[idx3];

    always @(posedge clk) begin
        if (ram_en1 && ram_wen1) mem1[idx1] <= (mem1[idx1] & ~ram_wmask1) | (ram_wdata1 & ram_wmask1);
        if (ram_en3 && ram_wen3) mem3[idx3] <= (mem3[idx3] & ~ram_wmask3) | (ram_wdata3 & ram_wmask3);
    end

    function automatic logic [63:0] w(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        cen1 = '0; wen1 = '0; addr1 = '0; wdata1 = '0; wmask1 = '0;
        cen3 = '0; wen3 = '0; addr3 = '0; wdata3 = '0; wmask3 = '0;
        repeat (2) @(negedge clk);
        #1;
        n_total++; if (rdy1 !== 2'b00) $display("FAIL reset_rdy1: got %b expected 00", rdy1); else n_pass++;
        n_total++; if (err1 !== 2'b00) $display("FAIL reset_err1: got %b expected 00", err1); else n_pass++;
        n_total++; if (rdata_o1 !== 128'd0) $display("FAIL reset_data1: got %h expected 0", rdata_o1); else n_pass++;
        n_total++; if (ram_en1 !== 1'b0) $display("FAIL reset_ram_en1: got %b expected 0", ram_en1); else n_pass++;
        n_total++; if (rdy3 !== 2'b00) $display("FAIL reset_rdy3: got %b expected 00", rdy3); else n_pass++;
        n_total++; if (rdata_o3 !== 128'd0) $display("FAIL reset_data3: got %h expected 0", rdata_o3); else n_pass++;
        @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        cen1 = 2'b01; wen1 = 2'b00; addr1[63:0] = 64'h8000_0010;
        #1;
        n_total++; if (gnt1 !== 2'b01) $display("FAIL single_gnt: got %b expected 01", gnt1); else n_pass++;
        n_total++; if (idx1 !== 16'd2) $display("FAIL single_idx: got %0d expected 2", idx1); else n_pass++;
        n_total++; if (ram_en1 !== 1'b1 || ram_wen1 !== 1'b0)
            $display("FAIL single_en_wen: got %b%b expected 10", ram_en1, ram_wen1); else n_pass++;
        @(negedge clk);
        cen1 = 2'b00;
        #1;
        n_total++; if (rdy1 !== 2'b01) $display("FAIL single_rdy: got %b expected 01", rdy1); else n_pass++;
        n_total++; if (err1 !== 2'b00) $display("FAIL single_err: got %b expected 00", err1); else n_pass++;
        n_total++; if (rdata_o1[63:0] !== w(2))
            $display("FAIL single_data: got %h expected %h", rdata_o1[63:0], w(2)); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (rdy1 !== 2'b00) $display("FAIL single_pulse: got %b expected 00", rdy1); else n_pass++;
        n_total++; if (rdata_o1[63:0] !== w(2))
            $display("FAIL single_hold: got %h expected %h", rdata_o1[63:0], w(2)); else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0] exp_g, exp_r;
        @(negedge clk);
        rst1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                rst1 = 1'b0;
                cen1 = 2'b11; wen1 = 2'b00;
                addr1 = {64'h8000_0018, 64'h8000_0000};
            end
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            n_total++; if (gnt1 !== exp_g) $display("FAIL contend_gnt[%0d]: got %b expected %b", k, gnt1, exp_g); else n_pass++;
            n_total++; if (rdy1 !== exp_r) $display("FAIL contend_rdy[%0d]: got %b expected %b", k, rdy1, exp_r); else n_pass++;
            if (k == 1) begin
                n_total++; if (rdata_o1[63:0] !== w(0))
                    $display("FAIL contend_data0: got %h expected %h", rdata_o1[63:0], w(0)); else n_pass++;
            end
            if (k == 2) begin
                n_total++; if (rdata_o1[127:64] !== w(3))
                    $display("FAIL contend_data1: got %h expected %h", rdata_o1[127:64], w(3)); else n_pass++;
            end
        end
        @(negedge clk);
        cen1 = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_masked_write();
        cen1 = 2'b10; wen1 = 2'b10;
        addr1[127:64] = 64'h8000_0008;
        wdata1[127:64] = 64'h1122_3344_5566_7788;
        wmask1 = 16'h0F00;
        #1;
        n_total++; if (gnt1 !== 2'b10) $display("FAIL wr_gnt: got %b expected 10", gnt1); else n_pass++;
        n_total++; if (ram_en1 !== 1'b1 || ram_wen1 !== 1'b1)
            $display("FAIL wr_en_wen: got %b%b expected 11", ram_en1, ram_wen1); else n_pass++;
        n_total++; if (idx1 !== 16'd1) $display("FAIL wr_idx: got %0d expected 1", idx1); else n_pass++;
        n_total++; if (ram_wmask1 !== 64'h0000_0000_FFFF_FFFF)
            $display("FAIL wr_mask: got %h expected 00000000ffffffff", ram_wmask1); else n_pass++;
        n_total++; if (ram_wdata1 !== 64'h1122_3344_5566_7788)
            $display("FAIL wr_data: got %h expected 1122334455667788", ram_wdata1); else n_pass++;
        @(negedge clk);
        cen1 = 2'b00; wen1 = 2'b00; wmask1 = '0;
        #1;
        n_total++; if (rdy1 !== 2'b10) $display("FAIL wr_rdy: got %b expected 10", rdy1); else n_pass++;
        n_total++; if (rdata_o1[127:64] !== w(3))
            $display("FAIL wr_keep_data: got %h expected %h", rdata_o1[127:64], w(3)); else n_pass++;
        @(negedge clk);
        cen1 = 2'b01; addr1[63:0] = 64'h8000_0008;
        #1;
        n_total++; if (gnt1 !== 2'b01 || idx1 !== 16'd1 || ram_wen1 !== 1'b0)
            $display("FAIL rd_after_wr_req: got gnt %b idx %0d wen %b expected 01 1 0", gnt1, idx1, ram_wen1);
        else n_pass++;
        @(negedge clk);
        cen1 = 2'b00;
        #1;
        n_total++; if (rdata_o1[63:0] !== 64'hC0DE_0000_5566_7788)
            $display("FAIL rd_after_wr_data: got %h expected c0de000055667788", rdata_o1[63:0]); else n_pass++;
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        cen1 = 2'b01; addr1[63:0] = 64'h7FFF_FFF8;
        #1;
        n_total++; if (gnt1 !== 2'b01 || ram_en1 !== 1'b0)
            $display("FAIL oor_low_req: got gnt %b en %b expected 01 0", gnt1, ram_en1); else n_pass++;
        @(negedge clk);
        cen1 = 2'b00;
        #1;
        n_total++; if (rdy1 !== 2'b01 || err1 !== 2'b01)
            $display("FAIL oor_low_rsp: got rdy %b err %b expected 01 01", rdy1, err1); else n_pass++;
        n_total++; if (rdata_o1[63:0] !== 64'd0)
            $display("FAIL oor_low_data: got %h expected 0", rdata_o1[63:0]); else n_pass++;
        @(negedge clk);
        cen1 = 2'b01; addr1[63:0] = 64'h8000_0010;
        #1;
        n_total++; if (ram_en1 !== 1'b1 || idx1 !== 16'd2)
            $display("FAIL inr_req: got en %b idx %0d expected 1 2", ram_en1, idx1); else n_pass++;
        @(negedge clk);
        cen1 = 2'b00;
        #1;
        n_total++; if (err1 !== 2'b00 || rdata_o1[63:0] !== w(2))
            $display("FAIL inr_rsp: got err %b data %h expected 00 %h", err1, rdata_o1[63:0], w(2)); else n_pass++;
        @(negedge clk);
        cen1 = 2'b01; addr1[63:0] = 64'h8008_0000;
        #1;
        n_total++; if (gnt1 !== 2'b01 || ram_en1 !== 1'b0)
            $display("FAIL oor_high_req: got gnt %b en %b expected 01 0", gnt1, ram_en1); else n_pass++;
        @(negedge clk);
        cen1 = 2'b00;
        #1;
        n_total++; if (rdy1 !== 2'b01 || err1 !== 2'b01 || rdata_o1[63:0] !== 64'd0)
            $display("FAIL oor_high_rsp: got rdy %b err %b data %h expected 01 01 0", rdy1, err1, rdata_o1[63:0]);
        else n_pass++;
        @(negedge clk);
        cen1 = 2'b01; addr1[63:0] = 64'h8007_FFF8;
        #1;
        n_total++; if (ram_en1 !== 1'b1 || idx1 !== 16'hFFFF)
            $display("FAIL top_word_req: got en %b idx %h expected 1 ffff", ram_en1, idx1); else n_pass++;
        @(negedge clk);
        cen1 = 2'b00;
        #1;
        n_total++; if (err1 !== 2'b00 || rdata_o1[63:0] !== 64'hC0DE_0000_0000_FFFF)
            $display("FAIL top_word_rsp: got err %b data %h expected 00 c0de00000000ffff", err1, rdata_o1[63:0]);
        else n_pass++;
    endtask

    task automatic test_latency();
        @(negedge clk);
        cen3 = 2'b01; wen3 = 2'b00; addr3[63:0] = 64'h8000_0020;
        #1;
        n_total++; if (gnt3 !== 2'b01) $display("FAIL lat_gnt_t0: got %b expected 01", gnt3); else n_pass++;
        @(negedge clk);
        cen3 = 2'b11; addr3[127:64] = 64'h8000_0028;
        #1;
        n_total++; if (gnt3 !== 2'b10 || rdy3 !== 2'b00)
            $display("FAIL lat_t1: got gnt %b rdy %b expected 10 00", gnt3, rdy3); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (gnt3 !== 2'b00 || rdy3 !== 2'b00)
            $display("FAIL lat_t2: got gnt %b rdy %b expected 00 00", gnt3, rdy3); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (gnt3 !== 2'b00 || rdy3 !== 2'b01)
            $display("FAIL lat_t3: got gnt %b rdy %b expected 00 01", gnt3, rdy3); else n_pass++;
        n_total++; if (rdata_o3[63:0] !== w(4))
            $display("FAIL lat_data0: got %h expected %h", rdata_o3[63:0], w(4)); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (gnt3 !== 2'b01 || rdy3 !== 2'b10)
            $display("FAIL lat_t4: got gnt %b rdy %b expected 01 10", gnt3, rdy3); else n_pass++;
        n_total++; if (rdata_o3[127:64] !== w(5))
            $display("FAIL lat_data1: got %h expected %h", rdata_o3[127:64], w(5)); else n_pass++;
        @(negedge clk);
        cen3 = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        logic seen;
        cen3 = 2'b01; addr3[63:0] = 64'h8000_0030;
        #1;
        n_total++; if (gnt3 !== 2'b01) $display("FAIL mid_gnt: got %b expected 01", gnt3); else n_pass++;
        @(negedge clk);
        cen3 = 2'b00;
        rst3 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) rst3 = 1'b0;
            #1;
            if (rdy3 !== 2'b00) seen = 1'b1;
            @(negedge clk);
        end
        n_total++; if (seen !== 1'b0) $display("FAIL mid_no_rsp: got pulse %b expected 0", seen); else n_pass++;
        n_total++; if (rdata_o3 !== 128'd0) $display("FAIL mid_data_clr: got %h expected 0", rdata_o3); else n_pass++;
        cen3 = 2'b11; addr3 = {64'h8000_0008, 64'h8000_0000};
        #1;
        n_total++; if (gnt3 !== 2'b01) $display("FAIL mid_first_gnt: got %b expected 01", gnt3); else n_pass++;
        @(negedge clk);
        cen3 = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 65536; i++) begin
            mem1[i] = w(i);
            mem3[i] = w(i);
        end
        test_reset();
        test_single_read();
        test_contention();
        test_masked_write();
        test_out_of_range();
        test_latency();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
